// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Responder end of the pipelined CPU data-memory interface.
//               Decodes each MEM-stage access to word RAM or to a small
//               memory-mapped I/O window (LED register, free-running cycle
//               counter, timer compare, sticky status, byte TX FIFO drained
//               over a valid/ready stream). Read data is combinational so the
//               CPU's MEM/WB register captures it at the next clock edge.
// Ports       : clk, rst        clock / synchronous active-high reset
//               Addr_in[31:0]   byte address (bits [1:0] ignored)
//               Data_in[31:0]   store data
//               MemRW           1 = write this cycle, 0 = read
//               Data_out[31:0]  combinational read data
//               leds[15:0]      LED register
//               tx_data[7:0]    TX FIFO head byte (0 while empty)
//               tx_valid        TX FIFO non-empty
//               tx_ready        consumer takes head when tx_valid && tx_ready
//               irq_timer       sticky timer-match status bit
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int          RAM_DEPTH  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic        MemRW,
  output logic [31:0] Data_out,
  output logic [15:0] leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq_timer
);

  localparam int c_RAM_AW  = $clog2(RAM_DEPTH);
  localparam int c_FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = c_FIFO_AW + 1;

  localparam logic [c_FIFO_AW-1:0] c_PTR_ONE  = c_FIFO_AW'(1);
  localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]   c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

  // Word offsets (Addr_in[7:2]) inside the I/O window
  localparam logic [5:0] c_OFF_LED    = 6'd0;
  localparam logic [5:0] c_OFF_CYCLE  = 6'd1;
  localparam logic [5:0] c_OFF_CMP    = 6'd2;
  localparam logic [5:0] c_OFF_STATUS = 6'd3;
  localparam logic [5:0] c_OFF_TXDATA = 6'd4;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [31:0]          r_ram [RAM_DEPTH];
  logic [7:0]           r_fifo [FIFO_DEPTH];
  logic [c_FIFO_AW-1:0] r_rd_ptr;
  logic [c_FIFO_AW-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [15:0]          r_leds;
  logic [31:0]          r_cycle;
  logic [31:0]          r_cmp;
  logic [1:0]           r_status;   // bit0 timer match, bit1 FIFO overflow

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic                w_is_io;
  logic [5:0]          w_off;
  logic [c_RAM_AW-1:0] w_ram_idx;
  logic                w_wr_io;
  logic                w_wr_led;
  logic                w_wr_cycle;
  logic                w_wr_cmp;
  logic                w_wr_status;
  logic                w_push_req;
  logic                w_unused;

  assign w_is_io     = (Addr_in[31:8] == IO_BASE[31:8]);
  assign w_off       = Addr_in[7:2];
  assign w_ram_idx   = Addr_in[c_RAM_AW+1:2];
  assign w_wr_io     = MemRW && w_is_io;
  assign w_wr_led    = w_wr_io && (w_off == c_OFF_LED);
  assign w_wr_cycle  = w_wr_io && (w_off == c_OFF_CYCLE);
  assign w_wr_cmp    = w_wr_io && (w_off == c_OFF_CMP);
  assign w_wr_status = w_wr_io && (w_off == c_OFF_STATUS);
  assign w_push_req  = w_wr_io && (w_off == c_OFF_TXDATA);

  // Byte-lane bits carry no meaning for word-only accesses
  assign w_unused = ^Addr_in[1:0];

  // --------------------------------------------------------------------------
  // FIFO handshake
  // --------------------------------------------------------------------------
  logic w_tx_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_overflow;

  assign w_tx_valid = (r_count != '0);
  assign w_full     = (r_count == c_CNT_FULL);
  assign w_pop      = w_tx_valid && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_overflow = w_push_req && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // Status next value: W1C clear first, then new events OR in so a
  // same-cycle set beats the clear.
  // --------------------------------------------------------------------------
  logic [1:0] w_status_clr;
  logic [1:0] w_status_set;
  logic [1:0] w_status_nxt;

  assign w_status_clr = w_wr_status ? Data_in[1:0] : 2'b00;
  assign w_status_set = {w_overflow, (r_cycle == r_cmp)};
  assign w_status_nxt = (r_status & ~w_status_clr) | w_status_set;

  // --------------------------------------------------------------------------
  // RAM: asynchronous read, no reset of contents, write blocked during rst
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && MemRW && !w_is_io) begin
      r_ram[w_ram_idx] <= Data_in;
    end
  end

  // FIFO storage has no reset; emptiness is tracked by r_count alone
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo[r_wr_ptr] <= Data_in[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_leds   <= 16'h0000;
      r_cycle  <= 32'h0000_0000;
      r_cmp    <= 32'hFFFF_FFFF;
      r_status <= 2'b00;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_led) begin
        r_leds <= Data_in[15:0];
      end

      // A CPU write replaces this cycle's increment
      if (w_wr_cycle) begin
        r_cycle <= Data_in;
      end else begin
        r_cycle <= r_cycle + 32'd1;
      end

      if (w_wr_cmp) begin
        r_cmp <= Data_in;
      end

      r_status <= w_status_nxt;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Combinational read mux
  // --------------------------------------------------------------------------
  always_comb begin
    Data_out = 32'h0000_0000;
    if (w_is_io) begin
      case (w_off)
        c_OFF_LED:    Data_out = {16'h0000, r_leds};
        c_OFF_CYCLE:  Data_out = r_cycle;
        c_OFF_CMP:    Data_out = r_cmp;
        c_OFF_STATUS: Data_out = {30'd0, r_status};
        c_OFF_TXDATA: Data_out = 32'(r_count);
        default:      Data_out = 32'h0000_0000;
      endcase
    end else begin
      Data_out = r_ram[w_ram_idx];
    end
  end

  assign leds      = r_leds;
  assign tx_valid  = w_tx_valid;
  assign tx_data   = w_tx_valid ? r_fifo[r_rd_ptr] : 8'h00;
  assign irq_timer = r_status[0];

endmodule
`default_nettype wire
